// File: rtl/mbox_wr_arbiter_pkg.sv
// Shared types and constants for the mailbox write arbiter.
// MBOX_ARB_HDR_EN adds the HDR state that prefixes each packet with a tag byte.
package mbox_arb_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [3:0] HDR_TAG = 4'hF;
    localparam int MAX_REQ = 16;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

`ifdef MBOX_ARB_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HDR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;
`endif

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbox_wr_arbiter_if.sv
// Requester word ports and mailbox byte port of the write arbiter.
interface mbox_wr_arbiter_if #(
    parameter int N_REQ = 2
);
    import mbox_arb_pkg::*;

    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_last_i;
    logic [N_REQ*WORD_W-1:0] req_dat_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ-1:0]        grant_o;
    logic                    busy_o;
    logic                    mbox_wr_o;
    logic [BYTE_W-1:0]       mbox_do_o;
    logic                    mbox_full_i;

    modport master (
        output req_valid_i, req_last_i, req_dat_i, mbox_full_i,
        input  req_ready_o, grant_o, busy_o, mbox_wr_o, mbox_do_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_dat_i, mbox_full_i,
        output req_ready_o, grant_o, busy_o, mbox_wr_o, mbox_do_o
    );

endinterface

// File: rtl/mbox_wr_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above rr_ptr, with wrap.
module rr_arbiter
    import mbox_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDXW  = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDXW-1:0]  idx,
    output logic             any
);

    int unsigned     pos;
    logic [IDXW-1:0] pos_idx;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = IDXW'(pos);
            if (!any && req[pos_idx]) begin
                any          = 1'b1;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mbox_wr_arbiter.sv
// Round-robin packet arbiter serialising 32-bit requester words onto the mailbox byte port.
// Define MBOX_ARB_HDR_EN to prefix each packet with header byte {4'hF, requester index}.
module mbox_wr_arbiter
    import mbox_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    mbox_wr_arbiter_if.slave bus
);

    localparam int IDXW = idx_width(N_REQ);

    state_t           state_q, state_d;
    logic [WB_DW-1:0] buf_q;
    logic [1:0]       byte_cnt_q;
    logic             last_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  rr_ptr_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic [IDXW-1:0]  sel_idx;
    logic [WB_DW-1:0] sel_word;
    logic             sel_last;
    logic             load;
    logic             shift;
    logic             done;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (bus.req_valid_i),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // In IDLE the word comes from the fresh winner; later words from the packet owner.
    assign sel_idx  = (state_q == ST_IDLE) ? pick_idx : idx_q;
    assign sel_word = bus.req_dat_i[sel_idx*WB_DW +: WB_DW];
    assign sel_last = bus.req_last_i[sel_idx];

    assign bus.grant_o = grant_q;
    assign bus.busy_o  = (state_q != ST_IDLE);

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = '0;
        bus.mbox_wr_o   = 1'b0;
        bus.mbox_do_o   = buf_q[WOU_DW-1:0];
        load            = 1'b0;
        shift           = 1'b0;
        done            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    bus.req_ready_o = pick_gnt;
                    load            = 1'b1;
`ifdef MBOX_ARB_HDR_EN
                    state_d         = ST_HDR;
`else
                    state_d         = ST_SHIFT;
`endif
                end
            end
            ST_GET: begin
                bus.req_ready_o = grant_q;
                if (|(bus.req_valid_i & grant_q)) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.mbox_wr_o = ~bus.mbox_full_i;
                if (!bus.mbox_full_i) begin
                    shift = 1'b1;
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        if (last_q) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GET;
                        end
                    end
                end
            end
`ifdef MBOX_ARB_HDR_EN
            ST_HDR: begin
                bus.mbox_wr_o = ~bus.mbox_full_i;
                bus.mbox_do_o = {HDR_TAG, 4'(idx_q)};
                if (!bus.mbox_full_i) begin
                    state_d = ST_SHIFT;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                buf_q      <= sel_word;
                last_q     <= sel_last;
                byte_cnt_q <= '0;
                if (state_q == ST_IDLE) begin
                    grant_q <= pick_gnt;
                    idx_q   <= pick_idx;
                end
            end else if (shift) begin
                buf_q      <= buf_q >> WOU_DW;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (done) begin
                grant_q  <= '0;
                rr_ptr_q <= (idx_q == IDXW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

endmodule
